// File: rtl/vec_mem_seq_pkg.sv
// Shared definitions for the vector load/store memory sequencer.
// Opcode values match the vector ALU encoding.
package vec_mem_seq_pkg;

  localparam logic [3:0] VLD = 4'b0100;
  localparam logic [3:0] VST = 4'b0101;

  localparam int ELEM_W   = 16;
  localparam int NUM_ELEM = 16;
  localparam int VEC_W    = ELEM_W * NUM_ELEM;
  localparam int ADDR_W   = 16;
  localparam int CNT_W    = $clog2(NUM_ELEM);

  localparam logic [CNT_W-1:0]  LAST_IDX     = CNT_W'(NUM_ELEM - 1);
  localparam logic [ADDR_W-1:0] BOUNDS_LIMIT = ADDR_W'((1 << ADDR_W) - NUM_ELEM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } vmem_state_t;

  function automatic logic isVecMemOp(input logic [3:0] opcode);
    return (opcode == VLD) || (opcode == VST);
  endfunction

endpackage

// File: rtl/vec_mem_seq_elem_sel.sv
// Combinational selector returning element i_sel of a packed vector.
module vec_elem_sel
  import vec_mem_seq_pkg::*;
(
  input  logic [VEC_W-1:0]  i_vec,
  input  logic [CNT_W-1:0]  i_sel,
  output logic [ELEM_W-1:0] o_elem
);

  assign o_elem = i_vec[i_sel*ELEM_W +: ELEM_W];

endmodule

// File: rtl/vec_mem_seq.sv
// VLD/VST sequencer: moves one 256-bit vector as 16 word accesses.
// Optional base-address bounds check enabled by defining VMEM_BOUNDS_CHK_EN.
module vec_mem_seq
  import vec_mem_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_is_store,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [VEC_W-1:0]  i_wdata_vec,
  output logic              o_busy,
  output logic              o_done,
  output logic [VEC_W-1:0]  o_rdata_vec,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [ELEM_W-1:0] o_mem_wdata,
  input  logic [ELEM_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_err
);

  vmem_state_t       r_state;
  vmem_state_t       w_nextState;
  logic [CNT_W-1:0]  r_count;
  logic              r_isStore;
  logic [ADDR_W-1:0] r_base;
  logic [VEC_W-1:0]  r_wdataVec;
  logic [VEC_W-1:0]  r_rdataVec;
  logic [ELEM_W-1:0] w_elem;
  logic              w_boundsErr;
  logic              w_xfer;

`ifdef VMEM_BOUNDS_CHK_EN
  logic r_boundsErr;

  assign w_boundsErr = (i_base_addr > BOUNDS_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_boundsErr <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_boundsErr <= w_boundsErr;
    end
  end

  assign o_err = (r_state == DONE) && r_boundsErr;
`else
  assign w_boundsErr = 1'b0;
  assign o_err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A rejected out-of-range request skips XFER and reports through DONE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = w_boundsErr ? DONE : XFER;
        end
      end
      XFER: begin
        if (i_mem_ack && r_count == LAST_IDX) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_isStore  <= 1'b0;
      r_base     <= '0;
      r_wdataVec <= '0;
      r_rdataVec <= '0;
    end else begin
      if (r_state == IDLE && i_start && !w_boundsErr) begin
        r_count    <= '0;
        r_isStore  <= i_is_store;
        r_base     <= i_base_addr;
        r_wdataVec <= i_wdata_vec;
      end else if (r_state == XFER && i_mem_ack) begin
        r_count <= r_count + CNT_W'(1);
        if (!r_isStore) begin
          r_rdataVec[r_count*ELEM_W +: ELEM_W] <= i_mem_rdata;
        end
      end
    end
  end

  vec_elem_sel u_elemSel (
    .i_vec  (r_wdataVec),
    .i_sel  (r_count),
    .o_elem (w_elem)
  );

  // Memory-side outputs come straight from registers, so they hold across stalls.
  assign w_xfer      = (r_state == XFER);
  assign o_busy      = w_xfer;
  assign o_done      = (r_state == DONE);
  assign o_mem_req   = w_xfer;
  assign o_mem_we    = w_xfer && r_isStore;
  assign o_mem_addr  = w_xfer ? (r_base + {{(ADDR_W-CNT_W){1'b0}}, r_count}) : '0;
  assign o_mem_wdata = (w_xfer && r_isStore) ? w_elem : '0;
  assign o_rdata_vec = r_rdataVec;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed self-checking bench for vec_mem_seq (default build, VMEM_BOUNDS_CHK_EN undefined).
// A behavioural word memory with programmable ack delay logs every accepted access.
module tb_vec_mem_seq;
  import vec_mem_seq_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iStart;
  logic         iIsStore;
  logic [15:0]  iBaseAddr;
  logic [255:0] iWdataVec;
  logic         oBusy;
  logic         oDone;
  logic [255:0] oRdataVec;
  logic         oMemReq;
  logic         oMemWe;
  logic [15:0]  oMemAddr;
  logic [15:0]  oMemWdata;
  logic [15:0]  memRdata;
  logic         memAck;
  logic         oErr;

  logic [15:0]  mem [0:65535];
  int           cyc = 0;
  int           startCyc = 0;
  int           ackDelay = 0;
  int           stallCnt = 0;
  int           checkCount = 0;
  int           passCount = 0;
  int           failCount = 0;
  int           doneCount = 0;
  int           errCount = 0;
  logic         stallCheckEn = 1'b0;
  logic [15:0]  stallBase = 16'h0;
  logic [255:0] stallVec = '0;
  int           stallLb = 0;

  logic [15:0]  logAddr[$];
  logic [15:0]  logData[$];
  logic         logWe[$];
  int           logCyc[$];

  vec_mem_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (iStart),
    .i_is_store  (iIsStore),
    .i_base_addr (iBaseAddr),
    .i_wdata_vec (iWdataVec),
    .o_busy      (oBusy),
    .o_done      (oDone),
    .o_rdata_vec (oRdataVec),
    .o_mem_req   (oMemReq),
    .o_mem_we    (oMemWe),
    .o_mem_addr  (oMemAddr),
    .o_mem_wdata (oMemWdata),
    .i_mem_rdata (memRdata),
    .i_mem_ack   (memAck),
    .o_err       (oErr)
  );

  always #5 clk = ~clk;

  assign memAck   = oMemReq && (stallCnt == ackDelay);
  assign memRdata = mem[oMemAddr];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    stallCnt <= (oMemReq && !memAck) ? stallCnt + 1 : 0;
    if (oMemReq && memAck) begin
      logAddr.push_back(oMemAddr);
      logData.push_back(oMemWdata);
      logWe.push_back(oMemWe);
      logCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // During a stall the request must keep pointing at the element still owed.
  always @(negedge clk) begin
    if (oDone) doneCount++;
    if (oErr) errCount++;
    if (stallCheckEn && oMemReq && !memAck) begin
      checkOutput("stall_addr", oMemAddr, stallBase + 16'(logAddr.size() - stallLb));
      checkOutput("stall_wdata", oMemWdata, stallVec[(logAddr.size() - stallLb)*16 +: 16]);
    end
  end

  task automatic applyStimulus(input logic isStore, input logic [15:0] base, input logic [255:0] vec);
    @(negedge clk);
    iIsStore  = isStore;
    iBaseAddr = base;
    iWdataVec = vec;
    iStart    = 1'b1;
    startCyc  = cyc;
    @(negedge clk);
    iStart    = 1'b0;
  endtask

  task automatic runUntilDone(input int limit, output int rel);
    rel = -1;
    for (int k = 0; k < limit; k++) begin
      if (oDone) begin
        rel = cyc - startCyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [255:0] loadVec;
    logic [255:0] storeVec;
    logic [255:0] wrapVec;
    logic [255:0] busyVec;
    logic [255:0] abortVec;
    logic [15:0]  ea;
    int           rel;
    int           lb;
    int           dc;

    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      ea = 16'hFFF8 + 16'(i);
      mem[ea] = 16'h5000 + 16'(i);
      mem[16'h0100 + 16'(i)] = 16'h1000 + 16'(i);
      mem[16'h0300 + 16'(i)] = 16'h3000 + 16'(i);
      loadVec[i*16 +: 16]  = 16'h1000 + 16'(i);
      storeVec[i*16 +: 16] = 16'hA000 + 16'(i);
      wrapVec[i*16 +: 16]  = 16'h5000 + 16'(i);
      busyVec[i*16 +: 16]  = 16'h3000 + 16'(i);
      abortVec[i*16 +: 16] = 16'hB000 + 16'(i);
    end

    rst_n = 1'b0;
    iStart = 1'b0;
    iIsStore = 1'b0;
    iBaseAddr = 16'h0;
    iWdataVec = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", oBusy, 0);
    checkOutput("rst_done", oDone, 0);
    checkOutput("rst_req", oMemReq, 0);
    checkOutput("rst_we", oMemWe, 0);
    checkOutput("rst_addr", oMemAddr, 0);
    checkOutput("rst_wdata", oMemWdata, 0);
    checkOutput("rst_rdata", oRdataVec, 0);
    checkOutput("rst_err", oErr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] zero-wait load from 0x0100");
    lb = logAddr.size();
    dc = doneCount;
    applyStimulus(1'b0, 16'h0100, '0);
    checkOutput("load_busy", oBusy, 1);
    checkOutput("load_req", oMemReq, 1);
    checkOutput("load_first_addr", oMemAddr, 16'h0100);
    runUntilDone(40, rel);
    checkOutput("load_done_cyc", rel, 17);
    checkOutput("load_busy_in_done", oBusy, 0);
    checkOutput("load_req_in_done", oMemReq, 0);
    repeat (2) @(negedge clk);
    checkOutput("load_count", logAddr.size() - lb, 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("load_addr", logAddr[lb+i], 16'h0100 + 16'(i));
      checkOutput("load_we", logWe[lb+i], 0);
    end
    checkOutput("load_first_req_cyc", logCyc[lb] - startCyc, 1);
    checkOutput("load_last_req_cyc", logCyc[lb+15] - startCyc, 16);
    checkOutput("load_elem0", oRdataVec[15:0], 16'h1000);
    checkOutput("load_elem15", oRdataVec[255:240], 16'h100F);
    checkOutput("load_vec", oRdataVec, loadVec);
    checkOutput("load_done_pulses", doneCount - dc, 1);

    $display("[TB] store to 0x0200 with two stall cycles per access");
    lb = logAddr.size();
    ackDelay = 2;
    stallBase = 16'h0200;
    stallVec = storeVec;
    stallLb = lb;
    stallCheckEn = 1'b1;
    applyStimulus(1'b1, 16'h0200, storeVec);
    runUntilDone(100, rel);
    stallCheckEn = 1'b0;
    ackDelay = 0;
    checkOutput("store_done_cyc", rel, 49);
    repeat (2) @(negedge clk);
    checkOutput("store_count", logAddr.size() - lb, 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("store_addr", logAddr[lb+i], 16'h0200 + 16'(i));
      checkOutput("store_data", logData[lb+i], 16'hA000 + 16'(i));
      checkOutput("store_we", logWe[lb+i], 1);
    end
    checkOutput("store_rdata_kept", oRdataVec, loadVec);

    $display("[TB] load wrapping past 0xFFFF");
    lb = logAddr.size();
    applyStimulus(1'b0, 16'hFFF8, '0);
    runUntilDone(40, rel);
    checkOutput("wrap_done_cyc", rel, 17);
    repeat (2) @(negedge clk);
    checkOutput("wrap_count", logAddr.size() - lb, 16);
    for (int i = 0; i < 16; i++) begin
      ea = 16'hFFF8 + 16'(i);
      checkOutput("wrap_addr", logAddr[lb+i], ea);
    end
    checkOutput("wrap_vec", oRdataVec, wrapVec);

    $display("[TB] start pulsed while busy");
    lb = logAddr.size();
    dc = doneCount;
    applyStimulus(1'b0, 16'h0300, '0);
    repeat (4) @(negedge clk);
    iIsStore = 1'b1;
    iBaseAddr = 16'h0400;
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    iIsStore = 1'b0;
    runUntilDone(40, rel);
    checkOutput("busy_done_cyc", rel, 17);
    repeat (4) @(negedge clk);
    checkOutput("busy_count", logAddr.size() - lb, 16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("busy_addr", logAddr[lb+i], 16'h0300 + 16'(i));
      checkOutput("busy_we", logWe[lb+i], 0);
    end
    checkOutput("busy_vec", oRdataVec, busyVec);
    checkOutput("busy_done_pulses", doneCount - dc, 1);

    $display("[TB] reset after seventh store ack");
    lb = logAddr.size();
    dc = doneCount;
    applyStimulus(1'b1, 16'h0500, abortVec);
    for (int k = 0; k < 40 && (logAddr.size() - lb) < 7; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_acks", logAddr.size() - lb, 7);
    checkOutput("abort_busy", oBusy, 0);
    checkOutput("abort_req", oMemReq, 0);
    checkOutput("abort_we", oMemWe, 0);
    checkOutput("abort_addr", oMemAddr, 0);
    checkOutput("abort_wdata", oMemWdata, 0);
    checkOutput("abort_rdata", oRdataVec, 0);
    checkOutput("abort_done", oDone, 0);
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", doneCount - dc, 0);
    checkOutput("abort_acks_after", logAddr.size() - lb, 7);
    checkOutput("abort_last_addr", logAddr[lb+6], 16'h0506);
    checkOutput("abort_last_data", logData[lb+6], 16'hB006);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 16'h0100, '0);
    runUntilDone(40, rel);
    checkOutput("post_rst_done_cyc", rel, 17);
    @(negedge clk);
    checkOutput("post_rst_vec", oRdataVec, loadVec);

    $display("[TB] start held high for back-to-back loads");
    lb = logAddr.size();
    dc = doneCount;
    @(negedge clk);
    iIsStore = 1'b0;
    iBaseAddr = 16'h0100;
    iStart = 1'b1;
    startCyc = cyc;
    @(negedge clk);
    runUntilDone(40, rel);
    checkOutput("b2b_first_done", rel, 17);
    @(negedge clk);
    runUntilDone(40, rel);
    checkOutput("b2b_second_done", rel, 35);
    iStart = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("b2b_count", logAddr.size() - lb, 32);
    checkOutput("b2b_done_pulses", doneCount - dc, 2);
    checkOutput("b2b_second_req_cyc", logCyc[lb+16] - startCyc, 19);
    checkOutput("b2b_vec", oRdataVec, loadVec);

    checkOutput("err_never", errCount, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/vec_mem_seq.md
Name: vec_mem_seq

Overview:
- Memory-side partner of the vector ALU for VLD/VST.
- The ALU computes the 16-bit effective address; this block performs the resulting 16-element transfer over a 16-bit-wide data-memory port.
- VLD: reads 16 consecutive words and assembles one 256-bit vector for register writeback.
- VST: splits a 256-bit vector into 16 word writes.

Parameters:
- ELEM_W, 16, element width in bits.
- NUM_ELEM, 16, elements per vector; vector width = ELEM_W*NUM_ELEM = 256.
- ADDR_W, 16, memory word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- is_store  in  1  1 = VST, 0 = VLD; sampled with start.
- base_addr  in  16  effective address from ALU result[15:0].
- wdata_vec  in  256  store vector; sampled with start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- rdata_vec  out  256  assembled load vector; element i at bits [16i+15:16i].
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_addr  out  16  word address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid when mem_ack=1.
- mem_ack  in  1  access complete this cycle.
- err  out  1  bounds error pulse; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset values (asynchronous): state=IDLE, count=0, busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_vec=0, err=0.
- FSM states: IDLE, XFER, DONE.
- IDLE: on start=1, latch is_store, base_addr and wdata_vec; set count=0; go to XFER. start is ignored in any other state.
- XFER:
  - mem_req=1, mem_addr=base+count (modulo 2^16, wraps 0xFFFF->0x0000), mem_we=is_store, mem_wdata=element[count].
  - mem_addr, mem_we and mem_wdata hold stable while mem_ack=0; unlimited stall allowed.
  - On mem_ack=1 during a load: rdata_vec[count] <= mem_rdata.
  - On mem_ack=1: count increments; when count==NUM_ELEM-1, go to DONE.
  - The next element's request is issued the cycle after an ack, so the peak rate is one element per cycle. An ack in the same cycle the request rises is legal.
- DONE: done=1 for exactly one cycle, mem_req=0, then return to IDLE. busy is low in DONE and IDLE.
- Latency with zero-wait memory (ack in the same cycle as the request): start at cycle 0, requests in cycles 1..16, done in cycle 17.
- rdata_vec:
  - Load-in-progress: elements not yet acked keep their previous values; the full vector is valid when done is asserted.
  - Holds until the next load overwrites it. Stores never modify it.
- mem_ack outside XFER is ignored.
- Reset asserted mid-transfer aborts immediately to reset values; no done pulse. Memory holds any partial store.
- A start asserted in the same cycle as done (DONE state) is ignored; the requester must re-assert it in IDLE.

Optional Feature:
- Macro VMEM_BOUNDS_CHK_EN.
- Defined: in IDLE, if start=1 and base_addr > 0xFFFF-(NUM_ELEM-1), the transfer is not started. err pulses high one cycle in the following cycle (via DONE with done=1, err=1). No memory access is made and rdata_vec is unchanged.
- Undefined: addresses wrap modulo 2^16 and err is constant 0.

Decomposition:
- Shared package contents:
  - opcode constants VLD=4'b0100 and VST=4'b0101, identical to the ALU encoding;
  - ELEM_W, NUM_ELEM and VEC_W=256;
  - the FSM state enum.
- One natural sub-module: vec_elem_sel, a combinational mux selecting wdata_vec element[count] as a 16-bit word. The rest stays in vec_mem_seq.

Test Plan:
- Load, zero-wait: memory[0x0100+i]=0x1000+i, start with is_store=0 and base 0x0100 -> 16 consecutive requests at 0x0100..0x010F, done at cycle 17, rdata_vec[15:0]=0x1000, rdata_vec[255:240]=0x100F.
- Store with stalls: wdata_vec element i=0xA000+i, base 0x0200, ack delayed 2 cycles per access -> mem_addr/mem_wdata stable across stalls, writes 0xA000..0xA00F to 0x0200..0x020F, done at cycle 49, rdata_vec unchanged.
- Wrap: load from base 0xFFF8 with the macro undefined -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007. With VMEM_BOUNDS_CHK_EN defined -> no mem_req, done=1 and err=1 in the same cycle.
- start while busy: pulse start at cycle 5 of a load with a different base -> ignored, original addresses continue, single done.
- Reset mid-op: deassert rst_n after the 7th ack of a store -> all outputs 0 immediately, no done. A new load after reset completes normally.
- Back-to-back: start held high continuously -> a new transfer begins in the IDLE cycle after each done. The start seen in the DONE cycle does not double-trigger.
